bd_word_deserializer: RTL
=========================

BD_WORD_DESERIALIZER -- requirements
Module: bd_word_deserializer

Interface
REQ-001 Parameter: CHUNK_W, 12, serialized payload chunk width; SHALL equal the SerializedBDWordChannel payload width.
REQ-002 Parameter: WORD_W, 32, reassembled payload width; SHALL equal the DecodedBDWordChannel payload width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in  SerializedBDWordChannel  -  input chunk stream; leaf_code[3:0], payload[11:0], v driven by upstream; a driven by this block.
REQ-006 Port: out  DecodedBDWordChannel  -  reassembled word stream; leaf_code[3:0], payload[31:0], v driven by this block; a driven by downstream.
REQ-007 Port: err_mismatch  output  1  one-cycle pulse; partial word discarded on leaf_code change.
REQ-008 Port: err_bad_code  output  1  one-cycle pulse; chunk with unmapped leaf_code dropped.

Function
REQ-009 A transfer on either channel SHALL occur on a rising clk edge where v and a are both 1; v SHALL NOT drop before its transfer.
REQ-010 The chunks-per-word count SHALL come from package table LEAF_NCHUNKS: codes 0-4 = 1, codes 5-8 = 2, codes 9-12 = 3, codes 13-15 = 0 (invalid).
REQ-011 Chunks SHALL be least-significant first: chunk k lands at payload[12k +: 12].
REQ-012 Chunk 2 bits [11:8] SHALL be discarded, and payload bits above the leaf's chunk count SHALL be 0.
REQ-013 States SHALL be IDLE (no partial word), ACCUM (partial word, count < n), and FULL (completed word held, out.v = 1).
REQ-014 IDLE: a valid chunk with n = 1 SHALL go to FULL; n > 1 SHALL latch leaf_code, store the chunk, set count = 1, and go to ACCUM.
REQ-015 ACCUM: a chunk with the latched leaf_code SHALL store, increment count, and go to FULL when count reaches n.
REQ-016 ACCUM: a chunk with a different valid leaf_code SHALL discard the partial word, pulse err_mismatch, and start a new word from that chunk per REQ-014.
REQ-017 A chunk with an invalid code SHALL be accepted and dropped, pulse err_bad_code, and leave state and partial data unchanged.
REQ-018 in.a SHALL equal !out.v || out.a (combinational); FULL with out.a = 1 SHALL accept a new chunk in the same cycle (full throughput, no bubble).
REQ-019 Latency SHALL be exactly 1 cycle: out.v asserts in the cycle after the final chunk transfer.
REQ-020 out.leaf_code and out.payload SHALL be stable while out.v = 1 and out.a = 0.
REQ-021 When a word leaves FULL with out.a = 1 and no input transfer occurs, the block SHALL return to IDLE.

Reset
REQ-022 On reset_n = 0, immediately and independent of clk: state = IDLE, count = 0, partial payload = 0, out.v = 0, out.leaf_code = 0, out.payload = 0, err_mismatch = 0, err_bad_code = 0.
REQ-023 Reset asserted mid-word SHALL discard the partial word with no output and no error pulse.
REQ-024 After reset release, in.a SHALL be 1 in the first cycle.

Structure
REQ-025 Package bd_pkg SHALL hold the LEAF_NCHUNKS table, CHUNK_W, WORD_W, and the state enum typedef.
REQ-026 The block SHALL be a single module with no sub-modules; the output register and accumulator SHALL share one sequential process.

Verification
REQ-027 Chunk leaf 2, payload 0xABC -> next cycle out.v = 1, leaf_code = 2, payload 0x00000ABC.
REQ-028 Chunks leaf 10: 0x123, 0x456, 0xF78, with out.a held 1 -> payload 0x78456123, err pulses 0.
REQ-029 Leaf 6 chunk 0x111, then leaf 3 chunk 0x222 -> err_mismatch pulses once, out gives leaf_code 3, payload 0x00000222; leaf 6 is never output.
REQ-030 out.a held 0 for 5 cycles after a word completes -> in.a = 0 and out is stable; on release, the next chunk is accepted in the same cycle.
REQ-031 Chunk leaf 14 inside an in-progress leaf 5 word -> err_bad_code pulses; the leaf 5 word completes normally with its next chunk.
REQ-032 reset_n pulsed low after the first of 3 chunks -> all outputs 0 at once; the next 3 chunks of leaf 9 form a clean word.

Source files
------------

// File: rtl/bd_pkg.sv
// Shared definitions for the BD word deserializer.
//   CHUNK_W / WORD_W : serialized chunk width and reassembled word width
//   LEAF_NCHUNKS     : chunks per word, indexed by leaf_code (0 = invalid code)
//   bd_state_e       : deserializer state encoding
//   place_chunk      : ORs a chunk into its little-endian slot of a word
package bd_pkg;

    localparam int CHUNK_W = 12;
    localparam int WORD_W  = 32;
    localparam int LEAF_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no partial word held
        ST_ACCUM = 2'd1,   // partial word, fewer than n chunks stored
        ST_FULL  = 2'd2    // completed word presented on the output
    } bd_state_e;

    localparam logic [1:0] LEAF_NCHUNKS [0:15] = '{
        2'd1, 2'd1, 2'd1, 2'd1, 2'd1,   // codes 0-4
        2'd2, 2'd2, 2'd2, 2'd2,         // codes 5-8
        2'd3, 2'd3, 2'd3, 2'd3,         // codes 9-12
        2'd0, 2'd0, 2'd0                // codes 13-15: unmapped
    };

    // Chunk idx lands at word[CHUNK_W*idx +: CHUNK_W]. The third chunk only
    // has room for its low 8 bits; the upper bits fall off the top here.
    function automatic logic [WORD_W-1:0] place_chunk(
        input logic [WORD_W-1:0]  acc,
        input logic [1:0]         idx,
        input logic [CHUNK_W-1:0] chunk
    );
        logic [3*CHUNK_W-1:0] wide;
        case (idx)
            2'd0:    wide = {{(2*CHUNK_W){1'b0}}, chunk};
            2'd1:    wide = {{CHUNK_W{1'b0}}, chunk, {CHUNK_W{1'b0}}};
            default: wide = {chunk, {(2*CHUNK_W){1'b0}}};
        endcase
        return acc | wide[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/bd_word_deserializer.sv
// Reassembles 12-bit chunks into 32-bit words, least-significant chunk first.
// The number of chunks per word is looked up from the chunk's leaf_code.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; a producer keeps valid (and its data) up until that edge.
//
// Ports:
//   clk, reset_n         clock; asynchronous active-low reset
//   in_leaf_code_i/in_payload_i/in_v_i, in_a_o     chunk input channel
//   out_leaf_code_o/out_payload_o/out_v_o, out_a_i word output channel
//   err_mismatch_o       1-cycle pulse: partial word dropped on leaf change
//   err_bad_code_o       1-cycle pulse: chunk with unmapped leaf_code dropped
//   state_o              current FSM state (bd_state_e encoding)
module bd_word_deserializer
    import bd_pkg::*;
#(
    parameter int CHUNK_W = 12,
    parameter int WORD_W  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         in_leaf_code_i,
    input  logic [CHUNK_W-1:0] in_payload_i,
    input  logic               in_v_i,
    output logic               in_a_o,
    output logic [3:0]         out_leaf_code_o,
    output logic [WORD_W-1:0]  out_payload_o,
    output logic               out_v_o,
    input  logic               out_a_i,
    output logic               err_mismatch_o,
    output logic               err_bad_code_o,
    output logic [1:0]         state_o
);

    bd_state_e         state_q;
    logic [1:0]        count_q;
    logic [3:0]        leaf_q;
    logic [WORD_W-1:0] acc_q;
    logic [3:0]        out_leaf_q;
    logic [WORD_W-1:0] out_payload_q;
    logic              out_v_q;
    logic              err_mismatch_q;
    logic              err_bad_code_q;

    logic              in_a;
    logic              in_xfer;
    logic              out_xfer;
    logic [1:0]        n_chunks;
    logic              bad_code;
    logic              start_new;
    logic              mismatch;
    logic [1:0]        idx;
    logic [1:0]        count_d;
    logic [WORD_W-1:0] word_d;
    logic              word_done;

    always_comb begin
        // Ready whenever the output slot is empty or being drained this edge,
        // so a held word and the next chunk can swap without a bubble.
        in_a      = !out_v_q || out_a_i;
        in_xfer   = in_v_i && in_a;
        out_xfer  = out_v_q && out_a_i;
        n_chunks  = LEAF_NCHUNKS[in_leaf_code_i];
        bad_code  = (n_chunks == 2'd0);
        // Any chunk that does not continue the partial word starts a new one.
        start_new = (state_q != ST_ACCUM) || (in_leaf_code_i != leaf_q);
        mismatch  = in_xfer && !bad_code && (state_q == ST_ACCUM) &&
                    (in_leaf_code_i != leaf_q);
        idx       = start_new ? 2'd0 : count_q;
        count_d   = idx + 2'd1;
        word_d    = place_chunk(start_new ? '0 : acc_q, idx, in_payload_i);
        word_done = (count_d == n_chunks);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            count_q        <= 2'd0;
            leaf_q         <= 4'd0;
            acc_q          <= '0;
            out_leaf_q     <= 4'd0;
            out_payload_q  <= '0;
            out_v_q        <= 1'b0;
            err_mismatch_q <= 1'b0;
            err_bad_code_q <= 1'b0;
        end else begin
            err_mismatch_q <= mismatch;
            err_bad_code_q <= in_xfer && bad_code;

            if (out_xfer) begin
                out_v_q <= 1'b0;
                state_q <= ST_IDLE;
            end

            // Bad-code chunks are consumed but touch nothing else.
            if (in_xfer && !bad_code) begin
                if (word_done) begin
                    out_v_q       <= 1'b1;
                    out_leaf_q    <= in_leaf_code_i;
                    out_payload_q <= word_d;
                    state_q       <= ST_FULL;
                    count_q       <= 2'd0;
                    acc_q         <= '0;
                end else begin
                    acc_q   <= word_d;
                    count_q <= count_d;
                    leaf_q  <= in_leaf_code_i;
                    state_q <= ST_ACCUM;
                end
            end
        end
    end

    assign in_a_o          = in_a;
    assign out_leaf_code_o = out_leaf_q;
    assign out_payload_o   = out_payload_q;
    assign out_v_o         = out_v_q;
    assign err_mismatch_o  = err_mismatch_q;
    assign err_bad_code_o  = err_bad_code_q;
    assign state_o         = state_q;

endmodule
